// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 letter transmitter.
// Scan-code table, break prefix, frame length and sequence FSM states.
// Optional macro PS2TX_BREAK_EN adds the break states (F0 + code).
package ps2_pkg;

    localparam int FRAME_LEN   = 11;
    localparam int NUM_LETTERS = 26;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    // Set-2 make codes for A..Z.
    localparam logic [7:0] SCAN_CODE [NUM_LETTERS] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
        8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
        8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

`ifdef PS2TX_BREAK_EN
    typedef enum logic [2:0] {
        IDLE,
        MAKE,
        GAP_M,
        BRK_F0,
        GAP_F,
        BRK_CODE,
        GAP_B
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        MAKE,
        GAP_M
    } state_t;
`endif

    function automatic logic [7:0] scan_code(input logic [4:0] idx);
        logic [7:0] code;
        code = 8'h00;
        if (idx < 5'(NUM_LETTERS)) begin
            code = SCAN_CODE[idx];
        end
        return code;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Sends one 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop).
// Ports: clock, resetn, code (byte), start -> clk, dat, busy, frame_done.
// frame_done is high during the last cycle of the stop bit's low half.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int HALF_DIV = 2000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] code,
    input  logic       start,
    output logic       clk,
    output logic       dat,
    output logic       busy,
    output logic       frame_done
);

    localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    logic [HW-1:0]        half_cnt;
    logic [3:0]           bit_idx;
    logic                 low_half;
    logic [FRAME_LEN-1:0] frame;
    logic                 half_end;

    assign half_end   = busy && (half_cnt == HALF_LAST);
    assign frame_done = half_end && low_half && (bit_idx == LAST_BIT);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk      <= 1'b1;
            dat      <= 1'b1;
            busy     <= 1'b0;
            half_cnt <= '0;
            bit_idx  <= '0;
            low_half <= 1'b0;
            frame    <= '1;
        end else if (start && !busy) begin
            // frame[0] is on the line now; the rest shifts down per bit.
            frame    <= {1'b1, ~^code, code, 1'b0};
            busy     <= 1'b1;
            clk      <= 1'b1;
            dat      <= 1'b0;
            half_cnt <= '0;
            bit_idx  <= '0;
            low_half <= 1'b0;
        end else if (busy) begin
            if (!half_end) begin
                half_cnt <= half_cnt + 1'b1;
            end else begin
                half_cnt <= '0;
                if (!low_half) begin
                    clk      <= 1'b0;
                    low_half <= 1'b1;
                end else begin
                    clk      <= 1'b1;
                    low_half <= 1'b0;
                    if (frame_done) begin
                        busy    <= 1'b0;
                        dat     <= 1'b1;
                        bit_idx <= '0;
                    end else begin
                        // Data moves only at the start of a high half.
                        bit_idx <= bit_idx + 1'b1;
                        dat     <= frame[1];
                        frame   <= {1'b1, frame[FRAME_LEN-1:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ps2_letter_tx.sv
// Keyboard emulator: turns a letter index 0..25 into set-2 PS/2 frames.
// Ports: clock, resetn, letter, valid -> ready, done, err, ps2_clk, ps2_dat.
// Macro PS2TX_BREAK_EN: also send F0 + make code (key release).
module ps2_letter_tx
    import ps2_pkg::*;
#(
    parameter int HALF_DIV = 2000,
    parameter int GAP      = 4000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] letter,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic       ps2_clk,
    output logic       ps2_dat
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    state_t      state;
    state_t      next;
    logic [4:0]  held_letter;
    logic [GW-1:0] gap_cnt;
    logic        gap_last;
    logic        in_gap;
    logic        accept;
    logic        bad_req;
    logic        start;
    logic [7:0]  code;
    logic        busy;
    logic        frame_done;

    assign accept   = (state == IDLE) && valid && (letter <= 5'd25);
    assign bad_req  = (state == IDLE) && valid && (letter > 5'd25);
    assign gap_last = (gap_cnt == GAP_LAST);

    ps2_frame_tx #(
        .HALF_DIV (HALF_DIV)
    ) u_frame (
        .clock      (clock),
        .resetn     (resetn),
        .code       (code),
        .start      (start),
        .clk        (ps2_clk),
        .dat        (ps2_dat),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:     if (accept)     next = MAKE;
            MAKE:     if (frame_done) next = GAP_M;
`ifdef PS2TX_BREAK_EN
            GAP_M:    if (gap_last)   next = BRK_F0;
            BRK_F0:   if (frame_done) next = GAP_F;
            GAP_F:    if (gap_last)   next = BRK_CODE;
            BRK_CODE: if (frame_done) next = GAP_B;
            GAP_B:    if (gap_last)   next = IDLE;
`else
            GAP_M:    if (gap_last)   next = IDLE;
`endif
            default:  next = IDLE;
        endcase
    end

    // The first frame launches one cycle after accept; later frames
    // launch from the gap's last cycle so each slot is exactly
    // 22*HALF_DIV+GAP cycles.
    always_comb begin
        ready  = (state == IDLE);
        start  = 1'b0;
        code   = scan_code(held_letter);
        in_gap = 1'b0;
        unique case (state)
            MAKE: begin
                start = !busy;
            end
            GAP_M: begin
                in_gap = 1'b1;
`ifdef PS2TX_BREAK_EN
                start = gap_last;
                code  = BREAK_PREFIX;
`endif
            end
`ifdef PS2TX_BREAK_EN
            GAP_F: begin
                in_gap = 1'b1;
                start  = gap_last;
            end
            GAP_B: begin
                in_gap = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            gap_cnt     <= '0;
            held_letter <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (in_gap && !gap_last) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (accept) begin
                held_letter <= letter;
            end
            done <= (state != IDLE) && (next == IDLE);
            err  <= bad_req;
        end
    end

endmodule

// File: tb/tb_ps2_letter_tx.sv
// Directed bench for ps2_letter_tx with HALF_DIV=4, GAP=8.
// Frames are captured on ps2_clk falling edges and decoded as a receiver would.
module tb_ps2_letter_tx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] letter = 5'd0;
    logic       valid = 1'b0;
    logic       ready;
    logic       done;
    logic       err;
    logic       ps2_clk;
    logic       ps2_dat;

`ifdef PS2TX_BREAK_EN
    localparam int NF = 3;
`else
    localparam int NF = 1;
`endif
    localparam int SLOT    = 22 * 4 + 8;
    localparam int DONE_AT = NF * SLOT + 1;

    ps2_letter_tx #(
        .HALF_DIV (4),
        .GAP      (8)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .letter  (letter),
        .valid   (valid),
        .ready   (ready),
        .done    (done),
        .err     (err),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat)
    );

    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges <= edges + 1;

    bit bits[$];
    always @(negedge ps2_clk) bits.push_back(ps2_dat);

    logic [7:0] tbl [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
        8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
        8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    int n_cmp = 0;
    int n_bad = 0;
    int rd = 0;
    int t0 = 0;
    logic [25:0] rx_held = '0;
    logic [25:0] rx_last = '0;
    bit rx_brk = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input logic [4:0] l);
        letter = l;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        t0 = edges;
    endtask

    task automatic wait_done(input string tag, input int exp);
        int n;
        n = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                n = edges - t0;
                break;
            end
            tick();
        end
        chk(tag, n, exp);
    endtask

    task automatic next_frame(output logic [10:0] w);
        w = 11'bx;
        if (bits.size() >= rd + 11) begin
            for (int i = 0; i < 11; i++) w[i] = bits[rd + i];
            rd += 11;
        end
    endtask

    task automatic chk_frames(input string tag, input logic [10:0] make_f);
        logic [10:0] w;
        chk({tag, "_nbits"}, bits.size() - rd, 11 * NF);
        next_frame(w);
        chk({tag, "_make"}, {21'd0, w}, {21'd0, make_f});
`ifdef PS2TX_BREAK_EN
        next_frame(w);
        chk({tag, "_f0"}, {21'd0, w}, 32'h7E0);
        next_frame(w);
        chk({tag, "_brk"}, {21'd0, w}, {21'd0, make_f});
`endif
        rd = bits.size();
    endtask

    // Minimal keyboard receiver: frame check, F0 handling, one-hot key.
    task automatic rx_decode(input string tag);
        logic [10:0] w;
        logic [25:0] oh;
        bit ok;
        while (bits.size() >= rd + 11) begin
            next_frame(w);
            ok = (w[0] == 1'b0) && (w[10] == 1'b1) && (w[9] == ~^w[8:1]);
            chk({tag, "_frame_ok"}, {31'd0, ok}, 32'd1);
            if (w[8:1] == 8'hF0) begin
                rx_brk = 1;
            end else begin
                oh = '0;
                for (int k = 0; k < 26; k++) begin
                    if (tbl[k] == w[8:1]) oh[k] = 1'b1;
                end
                if (rx_brk) begin
                    rx_held &= ~oh;
                    rx_brk = 0;
                end else begin
                    rx_held |= oh;
                    rx_last = oh;
                end
            end
        end
        rd = bits.size();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) tick();
        chk("reset_clk", ps2_clk, 1);
        chk("reset_dat", ps2_dat, 1);
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        resetn = 1'b1;
        tick();
        rd = bits.size();

        // Letter A
        request(5'd0);
        chk("a_ready_drop", ready, 0);
        chk("a_dat_edge0", ps2_dat, 1);
        tick();
        chk("a_start_bit", ps2_dat, 0);
        chk("a_start_clk", ps2_clk, 1);
        wait_done("a_done_cycle", DONE_AT);
        chk("a_ready_back", ready, 1);
        chk_frames("a", 11'h438);
        tick();
        chk("a_done_pulse", done, 0);

        // Letter Z
        request(5'd25);
        wait_done("z_done_cycle", DONE_AT);
        chk_frames("z", 11'h434);

        // Out-of-range letter
        letter = 5'd30;
        valid = 1'b1;
        tick();
        chk("err_pulse", err, 1);
        chk("err_ready", ready, 1);
        chk("err_clk", ps2_clk, 1);
        chk("err_dat", ps2_dat, 1);
        tick();
        chk("err_repeat", err, 1);
        valid = 1'b0;
        tick();
        chk("err_clear", err, 0);
        chk("err_no_bits", bits.size() - rd, 0);

        // B while busy with A is dropped
        request(5'd0);
        repeat (20) tick();
        letter = 5'd1;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("busy_ready", ready, 0);
        wait_done("busy_done_cycle", DONE_AT);
        chk_frames("busy", 11'h438);
        repeat (5) tick();
        chk("busy_no_more", bits.size() - rd, 0);
        chk("busy_idle", ready, 1);

        // Reset at cycle 50 of a transfer, then C
        request(5'd0);
        repeat (49) tick();
        chk("rst_pre_dat", ps2_dat, 0);
        resetn = 1'b0;
        tick();
        chk("rst_clk", ps2_clk, 1);
        chk("rst_dat", ps2_dat, 1);
        chk("rst_ready", ready, 1);
        resetn = 1'b1;
        tick();
        rd = bits.size();
        request(5'd2);
        wait_done("c_done_cycle", DONE_AT);
        chk_frames("c", 11'h642);

        // valid held: re-accepted right after done
        letter = 5'd0;
        valid = 1'b1;
        tick();
        t0 = edges;
        wait_done("bb_done_cycle", DONE_AT);
        tick();
        valid = 1'b0;
        t0 = edges;
        chk("bb_reaccept", ready, 0);
        wait_done("bb_done2_cycle", DONE_AT);
        rd = bits.size();

        // Loopback into a receiver model: H then I
        request(5'd7);
        wait_done("h_done_cycle", DONE_AT);
        rx_decode("h");
        chk("lb_h_onehot", {6'd0, rx_last}, 32'h80);
`ifdef PS2TX_BREAK_EN
        chk("lb_h_released", {6'd0, rx_held}, 32'h0);
`else
        chk("lb_h_held", {6'd0, rx_held}, 32'h80);
`endif
        request(5'd8);
        wait_done("i_done_cycle", DONE_AT);
        rx_decode("i");
        chk("lb_i_onehot", {6'd0, rx_last}, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
